// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit serializer and, later, the receiver.
//   - PARITY_* : parity mode encodings for the PARITY parameter
//   - tx_state_t : transmit frame sequencer states
//   - UART_DATA_BITS : default data width per frame
//   - parity_of() : parity bit for a data word under a given mode
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic parity_of(input logic [7:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Takes one word per frame over a valid/ready interface
// and shifts it out as start bit, data LSB first, optional parity, stop bit(s).
// Bit timing comes entirely from baud_tick (one-clk enable per bit period).
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   baud_tick  one-clk pulse per bit period
//   tx_valid   upstream has a word to send
//   tx_data    word to send, sampled only in the accept cycle
//   tx_ready   high while idle; accept happens on tx_valid && tx_ready
//   tx         registered serial output, idles high
//   tx_done    one-clk pulse when the last stop bit ends
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_serializer: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 parity_q, parity_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 tx_n, done_n;

  assign tx_ready = (state == S_IDLE);

  always_comb begin
    state_n    = state;
    data_n     = data_q;
    parity_n   = parity_q;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    tx_n       = tx;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        // A tick in this same cycle is not looked at: WAIT only reacts from the next cycle.
        if (tx_valid) begin
          data_n   = tx_data;
          parity_n = parity_of(8'(tx_data), PARITY);
          state_n  = S_WAIT;
        end
      end
      S_WAIT: if (baud_tick) begin
        state_n   = S_START;
        tx_n      = 1'b0;
        bit_cnt_n = '0;
      end
      S_START: if (baud_tick) begin
        state_n = S_DATA;
        tx_n    = data_q[0];
      end
      S_DATA: if (baud_tick) begin
        if (bit_cnt == LAST_BIT) begin
          if (PARITY != PARITY_NONE) begin
            state_n = S_PARITY;
            tx_n    = parity_q;
          end else begin
            state_n    = S_STOP;
            tx_n       = 1'b1;
            stop_cnt_n = 1'b0;
          end
        end else begin
          // tx follows the bit that becomes the new LSB after the shift
          data_n    = {1'b0, data_q[DATA_BITS-1:1]};
          tx_n      = data_q[1];
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_PARITY: if (baud_tick) begin
        state_n    = S_STOP;
        tx_n       = 1'b1;
        stop_cnt_n = 1'b0;
      end
      S_STOP: if (baud_tick) begin
        if (stop_cnt == LAST_STOP) begin
          // Back to IDLE together with the done pulse so a new word can be
          // accepted in the done cycle.
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          stop_cnt_n = stop_cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      data_q   <= '0;
      parity_q <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      data_q   <= data_n;
      parity_q <= parity_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      tx       <= tx_n;
      tx_done  <= done_n;
    end
  end

endmodule
